vec_regfile_param: RTL

- Parametrised successor to the scalar/vector register file in the vector execution datapath.
- Holds NREGS_S scalar registers and NREGS_V vector registers of LANES x WIDTH bits.
- Adds features the current file does not have:
  - positive-edge writes with same-cycle read bypass;
  - per-lane write masking;
  - a sequential init/clear engine with busy status, instead of a bulk reset load.
- Sits between decode (read addresses) and writeback (write port).

---
 rtl/vec_regfile_param.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vec_regfile_param.sv
// vec_regfile_param: scalar/vector register file with a sequential init/clear engine,
// per-lane masked vector writes and same-cycle read bypass.
// Optional build macro: RF_WRITE_CNT_EN adds a saturating accepted-write counter (wcount).
module vec_regfile_param #(
  parameter int LANES   = 16,
  parameter int WIDTH   = 32,
  parameter int NREGS_S = 16,
  parameter int NREGS_V = 16,
  parameter int AW      = 4,
  parameter int PC_REG  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   we,
  input  logic                   wsel_v,
  input  logic [2:0]             wcmd,
  input  logic [AW-1:0]          waddr,
  input  logic [LANES*WIDTH-1:0] wdata,
  input  logic [LANES-1:0]       wmask,
  input  logic [AW-1:0]          ra1,
  input  logic [AW-1:0]          ra2,
  input  logic                   rsel_v,
  input  logic [WIDTH-1:0]       r15,
  output logic [LANES*WIDTH-1:0] rd1,
  output logic [LANES*WIDTH-1:0] rd2,
  output logic                   busy,
  output logic [WIDTH-1:0]       pc_probe
`ifdef RF_WRITE_CNT_EN
  ,
  output logic [31:0]            wcount
`endif
);

  localparam int LW  = LANES * WIDTH;
  localparam int TOP = LANES - 1;
  localparam logic [LW-1:0] ONES_VEC = {LANES{WIDTH'(1)}};

  typedef enum logic {INIT, READY} state_t;

  state_t        state, state_next;
  logic [AW-1:0] idx, idx_next;

  logic [WIDTH-1:0] sreg [NREGS_S];
  logic [LW-1:0]    vreg [NREGS_V];

  logic wr_ok, wr_s, wr_v;

  // Write decode: only READY writes are accepted; wcmd 3'b101 redirects a vector write to scalar
  always_comb begin
    wr_ok = (state == READY) && we && !rst;
    wr_s  = wr_ok && (!wsel_v || (wcmd == 3'b101));
    wr_v  = wr_ok && wsel_v && (wcmd != 3'b101);
  end

  // Init engine next-state: walk every index once, then serve; clr restarts from READY only
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      INIT: begin
        idx_next = idx + 1'b1;
        if (idx == AW'(NREGS_S - 1)) state_next = READY;
      end
      READY: begin
        if (clr) begin
          state_next = INIT;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = INIT;
        idx_next   = '0;
      end
    endcase
  end

  // State and init index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Register arrays: init engine clears one index per cycle, otherwise accepted writes land
  always_ff @(posedge clk) begin
    if (!rst && state == INIT) begin
      sreg[idx] <= '0;
      vreg[idx] <= (idx == AW'(NREGS_V - 1)) ? ONES_VEC : '0;
    end else if (wr_s) begin
      sreg[waddr] <= wdata[TOP*WIDTH +: WIDTH];
    end else if (wr_v) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wmask[i]) vreg[waddr][i*WIDTH +: WIDTH] <= wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // One read port: vector lanes with masked bypass, top lane chosen by rsel_v (PC_REG never bypassed)
  function automatic logic [LW-1:0] read_port(input logic [AW-1:0] a);
    logic [LW-1:0] r;
    r = vreg[a];
    if (wr_v && waddr == a) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wmask[i]) r[i*WIDTH +: WIDTH] = wdata[i*WIDTH +: WIDTH];
      end
    end
    if (!rsel_v) begin
      if (a == AW'(PC_REG))          r[TOP*WIDTH +: WIDTH] = r15;
      else if (wr_s && waddr == a)   r[TOP*WIDTH +: WIDTH] = wdata[TOP*WIDTH +: WIDTH];
      else                           r[TOP*WIDTH +: WIDTH] = sreg[a];
    end
    if (state == INIT) r = '0;
    return r;
  endfunction

  // Combinational read ports and status
  always_comb begin
    rd1      = read_port(ra1);
    rd2      = read_port(ra2);
    busy     = (state == INIT);
    pc_probe = sreg[0];
  end

`ifdef RF_WRITE_CNT_EN
  // Saturating count of accepted READY writes; cleared on reset and on clr-driven re-init
  always_ff @(posedge clk) begin
    if (rst)                           wcount <= '0;
    else if (state == READY && clr)    wcount <= '0;
    else if ((wr_s || wr_v) && wcount != '1) wcount <= wcount + 32'd1;
  end
`endif

endmodule
